// File: rtl/xor_accumulator_if.sv
// Handshake bundle for xor_accumulator.
// slave = accumulator side, master = producer/consumer side.
interface xor_accumulator_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             abort;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_parity;
  logic             busy;

  modport slave (
    input  start, abort,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data, out_parity,
    input  out_ready,
    output busy
  );

  modport master (
    output start, abort,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data, out_parity,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/xor_accumulator.sv
// Frame XOR accumulator: XORs FRAME_LEN words,
// then holds result and parity until taken.
module xor_accumulator #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  xor_accumulator_if.slave   bus
);

  localparam int CW =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           st;
  state_t           st_d;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;

  // State, accumulator and word counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= IDLE;
      acc <= '0;
      cnt <= '0;
    end else begin
      st  <= st_d;
      acc <= acc_d;
      cnt <= cnt_d;
    end
  end

  // Next state; abort overrides every other input
  always_comb begin
    st_d  = st;
    acc_d = acc;
    cnt_d = cnt;
    unique case (st)
      IDLE: begin
        if (bus.start) begin
          st_d  = ACC;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          acc_d = acc ^ bus.in_data;
          cnt_d = cnt + CW'(1);
          if (cnt == LAST) begin
            st_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          if (bus.start) begin
            st_d  = ACC;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            st_d = IDLE;
          end
        end
      end
      default: begin
        st_d  = IDLE;
        acc_d = '0;
        cnt_d = '0;
      end
    endcase
    if (bus.abort) begin
      st_d  = IDLE;
      acc_d = '0;
      cnt_d = '0;
    end
  end

  assign bus.in_ready   = (st == ACC);
  assign bus.out_valid  = (st == DONE);
  assign bus.busy       = (st != IDLE);
  assign bus.out_data   = acc;
  assign bus.out_parity = ^acc;

endmodule

// File: tb/tb_xor_accumulator.sv
// Bench for xor_accumulator: scoreboarded frames
// on 8x4 instance plus a 1x1 edge instance.
module tb_xor_accumulator;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  xor_accumulator_if #(.WIDTH(8)) b0 ();
  xor_accumulator_if #(.WIDTH(1)) b1 ();

  xor_accumulator #(
    .WIDTH(8),
    .FRAME_LEN(4)
  ) u0 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b0.slave)
  );

  xor_accumulator #(
    .WIDTH(1),
    .FRAME_LEN(1)
  ) u1 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b1.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] sbq[$];
  logic [7:0] acc_m;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    acc_m = 8'h00;
  endtask

  task automatic send(
    input logic [7:0] d,
    input int         gap
  );
    b0.in_valid = 1'b1;
    b0.in_data  = d;
    @(negedge clk);
    check("in_ready", 32'(b0.in_ready), 1);
    check("early_valid", 32'(b0.out_valid), 0);
    tick();
    b0.in_valid = 1'b0;
    b0.in_data  = 8'($urandom);
    acc_m = acc_m ^ d;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check("gap_ready", 32'(b0.in_ready), 1);
      tick();
    end
  endtask

  task automatic frame_end();
    sbq.push_back({^acc_m, acc_m});
  endtask

  task automatic get_out(input int hold);
    logic [8:0] e;
    @(negedge clk);
    check("out_valid", 32'(b0.out_valid), 1);
    if (sbq.size() == 0) begin
      check("sb_empty", 32'(sbq.size()), 1);
    end else begin
      e = sbq.pop_front();
      check("out_data", 32'(b0.out_data), 32'(e[7:0]));
      check("out_par", 32'(b0.out_parity), 32'(e[8]));
      for (int i = 1; i < hold; i++) begin
        tick();
        @(negedge clk);
        check("hold_valid", 32'(b0.out_valid), 1);
        check("hold_data", 32'(b0.out_data),
              32'(e[7:0]));
        check("hold_par", 32'(b0.out_parity),
              32'(e[8]));
      end
    end
  endtask

  task automatic drain();
    b0.out_ready = 1'b1;
    tick();
    b0.out_ready = 1'b0;
    @(negedge clk);
    check("drop_valid", 32'(b0.out_valid), 0);
    check("drop_busy", 32'(b0.busy), 0);
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    b0.start     = 1'b0;
    b0.abort     = 1'b0;
    b0.in_valid  = 1'b0;
    b0.in_data   = 8'h00;
    b0.out_ready = 1'b0;
    b1.start     = 1'b0;
    b1.abort     = 1'b0;
    b1.in_valid  = 1'b0;
    b1.in_data   = 1'b0;
    b1.out_ready = 1'b0;
    acc_m        = 8'h00;
    #2;
    check("rst_valid", 32'(b0.out_valid), 0);
    check("rst_ready", 32'(b0.in_ready), 0);
    check("rst_busy", 32'(b0.busy), 0);
    check("rst_data", 32'(b0.out_data), 0);
    check("rst1_busy", 32'(b1.busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // basic frame
    frame_start();
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h04, 0);
    send(8'h08, 0);
    frame_end();
    get_out(1);
    drain();

    // stalls and back-pressure
    frame_start();
    send(8'hFF, 2);
    send(8'h0F, 2);
    send(8'hAA, 2);
    send(8'h55, 0);
    frame_end();
    get_out(3);
    drain();

    // abort mid-frame
    frame_start();
    send(8'hAA, 0);
    send(8'h33, 0);
    b0.abort = 1'b1;
    tick();
    b0.abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(b0.busy), 0);
    check("abort_data", 32'(b0.out_data), 0);
    tick();
    frame_start();
    send(8'h80, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    frame_end();
    get_out(1);
    drain();

    // back-to-back frames
    frame_start();
    send(8'hC3, 0);
    send(8'h11, 0);
    send(8'h07, 0);
    send(8'h90, 0);
    frame_end();
    get_out(1);
    b0.start     = 1'b1;
    b0.out_ready = 1'b1;
    tick();
    b0.start     = 1'b0;
    b0.out_ready = 1'b0;
    acc_m        = 8'h00;
    @(negedge clk);
    check("b2b_ready", 32'(b0.in_ready), 1);
    check("b2b_valid", 32'(b0.out_valid), 0);
    tick();
    send(8'h3C, 0);
    send(8'h01, 1);
    send(8'h10, 0);
    send(8'h66, 0);
    frame_end();
    get_out(1);
    drain();

    // async reset mid-frame
    frame_start();
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h44, 0);
    @(negedge clk);
    check("pre_rst_busy", 32'(b0.busy), 1);
    check("pre_rst_data", 32'(b0.out_data), 32'h77);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(b0.busy), 0);
    check("arst_ready", 32'(b0.in_ready), 0);
    check("arst_valid", 32'(b0.out_valid), 0);
    check("arst_data", 32'(b0.out_data), 0);
    check("arst_par", 32'(b0.out_parity), 0);
    #1 rst_n = 1'b1;
    tick();
    b0.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b0.in_data = 8'($urandom);
      @(negedge clk);
      check("post_rst_valid", 32'(b0.out_valid), 0);
      check("post_rst_busy", 32'(b0.busy), 0);
      tick();
    end
    b0.in_valid = 1'b0;

    // start on the first edge after release
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n    = 1'b1;
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    acc_m    = 8'h00;
    @(negedge clk);
    check("first_start", 32'(b0.busy), 1);
    tick();
    send(8'h5A, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    frame_end();
    get_out(1);
    drain();

    // FRAME_LEN=1, WIDTH=1 instance
    b1.start = 1'b1;
    tick();
    b1.start    = 1'b0;
    b1.in_valid = 1'b1;
    b1.in_data  = 1'b1;
    @(negedge clk);
    check("e_ready", 32'(b1.in_ready), 1);
    check("e_early", 32'(b1.out_valid), 0);
    tick();
    b1.in_valid = 1'b0;
    b1.in_data  = 1'b0;
    @(negedge clk);
    check("e_valid", 32'(b1.out_valid), 1);
    check("e_data", 32'(b1.out_data), 1);
    check("e_par", 32'(b1.out_parity), 1);
    check("e_noacc", 32'(b1.in_ready), 0);
    b1.out_ready = 1'b1;
    tick();
    b1.out_ready = 1'b0;
    @(negedge clk);
    check("e_drop", 32'(b1.out_valid), 0);
    check("e_idle", 32'(b1.busy), 0);

    check("sb_left", 32'(sbq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
